// File: rtl/fb_rle_uart_tx.sv
// Framebuffer run-length encoder: reads FRAME_SIZE bytes from a synchronous memory
// and streams (count, value) pairs to a byte uart using a tx_start/tx_busy handshake.
module fb_rle_uart_tx #(
  parameter int FRAME_SIZE = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  input  logic              tx_busy
);
  localparam logic [ADDR_W:0] FRAME_END = (ADDR_W+1)'(FRAME_SIZE);
  localparam logic [ADDR_W:0] ADDR_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [3:0] {
    IDLE, READ, CAPTURE, EMIT_CNT, EMIT_VAL, TX_WAIT_HI, TX_WAIT_LO, AFTER_VAL, FINISH
  } state_t;

  state_t          state, state_nx, ret_state, ret_nx;
  logic [ADDR_W:0] rd_addr, rd_addr_nx;
  logic [7:0]      run_val, run_val_nx;
  logic [7:0]      run_cnt, run_cnt_nx;
  logic [7:0]      pend_val, pend_val_nx;
  logic            have_pend, have_pend_nx;
  logic            last, last_nx;
  logic            run_break;
  logic            in_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ret_state <= IDLE;
      rd_addr   <= '0;
      run_val   <= 8'h00;
      run_cnt   <= 8'h00;
      pend_val  <= 8'h00;
      have_pend <= 1'b0;
      last      <= 1'b0;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;
      rd_addr   <= rd_addr_nx;
      run_val   <= run_val_nx;
      run_cnt   <= run_cnt_nx;
      pend_val  <= pend_val_nx;
      have_pend <= have_pend_nx;
      last      <= last_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    ret_nx       = ret_state;
    rd_addr_nx   = rd_addr;
    run_val_nx   = run_val;
    run_cnt_nx   = run_cnt;
    pend_val_nx  = pend_val;
    have_pend_nx = have_pend;
    last_nx      = last;
    run_break    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          rd_addr_nx   = '0;
          have_pend_nx = 1'b0;
          last_nx      = 1'b0;
          state_nx     = READ;
        end
      end
      READ: begin
        rd_addr_nx = rd_addr + ADDR_ONE;
        state_nx   = CAPTURE;
      end
      CAPTURE: begin
        // rd_addr was already advanced, so the first byte of the frame shows up as rd_addr==1
        if (rd_addr == ADDR_ONE) begin
          run_val_nx = mem_data;
          run_cnt_nx = 8'h00;
        end else if (mem_data == run_val && run_cnt != 8'hFF) begin
          run_cnt_nx = run_cnt + 8'd1;
        end else begin
          run_break    = 1'b1;
          pend_val_nx  = mem_data;
          have_pend_nx = 1'b1;
          state_nx     = EMIT_CNT;
        end
        if (!run_break) begin
          if (rd_addr < FRAME_END) begin
            state_nx = READ;
          end else begin
            last_nx      = 1'b1;
            have_pend_nx = 1'b0;
            state_nx     = EMIT_CNT;
          end
        end
      end
      EMIT_CNT: begin
        if (!tx_busy) begin
          ret_nx   = EMIT_VAL;
          state_nx = TX_WAIT_HI;
        end
      end
      EMIT_VAL: begin
        if (!tx_busy) begin
          ret_nx   = AFTER_VAL;
          state_nx = TX_WAIT_HI;
        end
      end
      TX_WAIT_HI: if (tx_busy) state_nx = TX_WAIT_LO;
      TX_WAIT_LO: if (!tx_busy) state_nx = ret_state;
      AFTER_VAL: begin
        // the byte that broke the run seeds the next run
        if (have_pend) begin
          run_val_nx   = pend_val;
          run_cnt_nx   = 8'h00;
          have_pend_nx = 1'b0;
        end
        if (last && !have_pend) begin
          state_nx = FINISH;
        end else if (rd_addr < FRAME_END) begin
          state_nx = READ;
        end else begin
          last_nx  = 1'b1;
          state_nx = EMIT_CNT;
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_wait  = (state == TX_WAIT_HI) || (state == TX_WAIT_LO);
  assign busy     = (state != IDLE) && (state != FINISH);
  assign done     = (state == FINISH);
  assign mem_rd   = (state == READ);
  assign mem_addr = rd_addr[ADDR_W-1:0];
  assign tx_start = ((state == EMIT_CNT) || (state == EMIT_VAL)) && !tx_busy;

  // tx_byte follows the field being sent until the uart has finished with it
  always_comb begin
    tx_byte = 8'h00;
    if (state == EMIT_VAL || (in_wait && ret_state == AFTER_VAL)) begin
      tx_byte = run_val;
    end else if (state == EMIT_CNT || (in_wait && ret_state == EMIT_VAL)) begin
      tx_byte = run_cnt;
    end
  end

endmodule

// File: tb/tb_fb_rle_uart_tx.sv
// Bench for fb_rle_uart_tx: framebuffer and uart models, a greedy RLE reference and
// a pair decoder that rebuilds the frame from the transmitted bytes.
`timescale 1ns/1ps
module tb_fb_rle_uart_tx;
  localparam int FRAME_SIZE = 1024;
  localparam int ADDR_W     = 10;
  localparam int TIMEOUT    = 30000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, mem_rd, tx_start;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data = 8'h00;
  logic [7:0]        tx_byte;
  logic              tx_busy = 1'b0;

  logic [7:0] fb [FRAME_SIZE];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] lit_q[$];

  int checks = 0;
  int errors = 0;
  int busy_len = 10;
  int busy_left = 0;
  int exp_addr = 0;
  int rd_count = 0;
  bit done_seen = 1'b0;
  bit hold_active = 1'b0;
  bit hold_seen_busy = 1'b0;
  logic [7:0] held_byte = 8'h00;
  logic prev_tx_start = 1'b0;
  logic prev_done = 1'b0;

  fb_rle_uart_tx #(.FRAME_SIZE(FRAME_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .tx_start(tx_start), .tx_byte(tx_byte), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // synchronous framebuffer: data one cycle after the strobe
  always @(posedge clk) if (mem_rd) mem_data <= fb[mem_addr];

  // uart: busy for busy_len cycles after each accepted byte
  always @(posedge clk) begin
    if (tx_start && !tx_busy) begin
      tx_busy   <= 1'b1;
      busy_left <= busy_len;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      busy_left <= 0;
      tx_busy   <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // greedy reference: longest run of equal bytes, capped at 256
  task automatic build_expected();
    int i = 0;
    int n;
    exp_q.delete();
    while (i < FRAME_SIZE) begin
      n = 1;
      while (i + n < FRAME_SIZE && fb[i+n] == fb[i] && n < 256) n++;
      exp_q.push_back(8'(n - 1));
      exp_q.push_back(fb[i]);
      i += n;
    end
  endtask

  task automatic pin_literal(input string name, input bit use_rx);
    int bad = 0;
    int sz;
    sz = use_rx ? rx_q.size() : exp_q.size();
    checkOutput({name, " length"}, sz, lit_q.size());
    for (int k = 0; k < lit_q.size() && k < sz; k++)
      if ((use_rx ? rx_q[k] : exp_q[k]) !== lit_q[k]) bad++;
    checkOutput({name, " bytes differing"}, bad, 0);
  endtask

  task automatic verify_frame(input string name);
    int pos = 0;
    int bad = 0;
    checkOutput({name, " odd byte count"}, rx_q.size() % 2, 0);
    for (int k = 0; k + 1 < rx_q.size(); k += 2)
      for (int r = 0; r <= int'(rx_q[k]); r++) begin
        if (pos < FRAME_SIZE && fb[pos] !== rx_q[k+1]) bad++;
        pos++;
      end
    checkOutput({name, " decoded length"}, pos, FRAME_SIZE);
    checkOutput({name, " decoded bytes differing"}, bad, 0);
    checkOutput({name, " mem reads"}, rd_count, FRAME_SIZE);
    checkOutput({name, " busy after frame"}, busy, 0);
  endtask

  task automatic applyStimulus(input int blen, input int extra_at);
    int cyc = 0;
    busy_len = blen;
    build_expected();
    rx_q.delete();
    rd_count  = 0;
    exp_addr  = 0;
    done_seen = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checkOutput("busy after start", busy, 1);
    while (!done_seen && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == extra_at);
    end
    start = 1'b0;
    if (!done_seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done timeout: got no done after %0d cycles, expected a done pulse", cyc);
    end
  endtask

  // compare process: protocol rules and model bytes on every cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("outputs in reset", {busy, done, mem_rd, tx_start, mem_addr, tx_byte}, 0);
      hold_active   = 1'b0;
      exp_addr      = 0;
      prev_tx_start = 1'b0;
      prev_done     = 1'b0;
    end else begin
      if (mem_rd) begin
        checkOutput("mem_addr", 32'(mem_addr), exp_addr);
        exp_addr++;
        rd_count++;
      end
      if (tx_start) begin
        checkOutput("tx_start while tx_busy", tx_busy, 0);
        checkOutput("tx_start back-to-back", prev_tx_start, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL extra tx byte: got 0x%0h, expected no transmission", tx_byte);
        end else begin
          checkOutput("tx_byte", tx_byte, exp_q.pop_front());
        end
        rx_q.push_back(tx_byte);
        hold_active    = 1'b1;
        hold_seen_busy = 1'b0;
        held_byte      = tx_byte;
      end else if (hold_active) begin
        if (tx_busy) hold_seen_busy = 1'b1;
        else if (hold_seen_busy) hold_active = 1'b0;
        if (hold_active) checkOutput("tx_byte hold", tx_byte, held_byte);
      end
      if (done) begin
        checkOutput("busy during done", busy, 0);
        checkOutput("done width", prev_done, 0);
        checkOutput("bytes left at done", exp_q.size(), 0);
        done_seen = 1'b1;
      end
      prev_tx_start = tx_start;
      prev_done     = done;
    end
  end

  initial begin
    int cyc;
    int pos;
    int len;
    logic [7:0] v;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < FRAME_SIZE; i++) fb[i] = 8'h00;
    build_expected();
    lit_q = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    pin_literal("all-zero model", 1'b0);
    applyStimulus(10, 0);
    pin_literal("all-zero tx", 1'b1);
    verify_frame("all-zero");

    for (int i = 0; i < FRAME_SIZE; i++) fb[i] = (i % 2 == 0) ? 8'hAA : 8'h55;
    applyStimulus(1, 0);
    checkOutput("alternating tx count", rx_q.size(), 2048);
    verify_frame("alternating");

    for (int i = 0; i < FRAME_SIZE; i++) fb[i] = (i < 300) ? 8'h11 : 8'h22;
    build_expected();
    lit_q = '{8'hFF, 8'h11, 8'h2B, 8'h11, 8'hFF, 8'h22, 8'hFF, 8'h22, 8'hD3, 8'h22};
    pin_literal("split model", 1'b0);
    applyStimulus(3, 0);
    pin_literal("split tx", 1'b1);
    verify_frame("split");

    for (int i = 0; i < FRAME_SIZE; i++) fb[i] = (i == FRAME_SIZE - 1) ? 8'h7E : 8'h00;
    build_expected();
    lit_q = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h7E};
    pin_literal("last-differs model", 1'b0);
    applyStimulus(2, 0);
    pin_literal("last-differs tx", 1'b1);
    verify_frame("last-differs");

    for (int i = 0; i < FRAME_SIZE; i++) fb[i] = (i < 300) ? 8'h11 : 8'h22;
    lit_q = '{8'hFF, 8'h11, 8'h2B, 8'h11, 8'hFF, 8'h22, 8'hFF, 8'h22, 8'hD3, 8'h22};
    applyStimulus(3, 500);
    pin_literal("restart-ignored tx", 1'b1);
    verify_frame("restart-ignored");

    build_expected();
    rx_q.delete();
    exp_addr = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (rx_q.size() < 3 && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("bytes before abort", rx_q.size(), 3);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 checkOutput("outputs zero at abort", {busy, done, mem_rd, tx_start, mem_addr, tx_byte}, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 checkOutput("idle after abort", {busy, tx_start, mem_rd}, 0);
    applyStimulus(3, 0);
    pin_literal("after-abort tx", 1'b1);
    verify_frame("after-abort");

    for (int f = 0; f < 10; f++) begin
      pos = 0;
      while (pos < FRAME_SIZE) begin
        if ($urandom_range(0, 3) == 0) begin
          len = 1;
          v   = 8'($urandom_range(0, 255));
        end else begin
          len = $urandom_range(1, 400);
          v   = 8'($urandom_range(0, 3));
        end
        for (int k = 0; k < len && pos < FRAME_SIZE; k++) begin
          fb[pos] = v;
          pos++;
        end
      end
      applyStimulus(1, 0);
      verify_frame($sformatf("random frame %0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
